// File: rtl/alu_ctr_select_seq.sv
// Registered ALU-control select with a sequenced multi-cycle path (start pulse, stall window, done strobe).
// Optional flush of an in-flight multi-cycle op is enabled by defining ALU_CTR_SELECT_FLUSH_EN.
module alu_ctr_select_seq #(
    parameter int               CTR_W      = 3,
    parameter int               FUNC_W     = 3,
    parameter logic [CTR_W-1:0] RTYPE_CODE = {CTR_W{1'b1}},
    parameter logic [CTR_W-1:0] MC_CODE    = CTR_W'(3'b101),
    parameter int               MC_LAT     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef ALU_CTR_SELECT_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTR_W-1:0]  ALUop,
    input  logic [FUNC_W-1:0] func_bits,
    output logic [CTR_W-1:0]  alu_ctr,
    output logic              is_r_type,
    output logic              out_valid,
    output logic              mc_start,
    output logic              stall,
    output logic              dbg_state
);

    localparam int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic               r_q, r_d;
    logic               ov_q, ov_d;
    logic               mcs_q, mcs_d;
    logic               flush_act;
    logic               r_sel;
    logic [CTR_W-1:0]   func_ext;
    logic [CTR_W-1:0]   sel;
    logic               accept;

`ifdef ALU_CTR_SELECT_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    generate
        if (FUNC_W < CTR_W) begin : g_ext
            assign func_ext = {{(CTR_W-FUNC_W){1'b0}}, func_bits};
        end else if (FUNC_W > CTR_W) begin : g_trunc
            assign func_ext = func_bits[CTR_W-1:0];
        end else begin : g_same
            assign func_ext = func_bits;
        end
    endgenerate

    assign r_sel = (ALUop == RTYPE_CODE);
    assign sel   = r_sel ? func_ext : ALUop;

    // Handshake: a request transfers on a cycle where in_valid && in_ready; upstream
    // holds ALUop/func_bits stable while in_ready is low. Outputs have no backpressure.
    assign in_ready = (state_q == IDLE) && !flush_act;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctr_d   = ctr_q;
        r_d     = r_q;
        ov_d    = 1'b0;
        mcs_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ctr_d = sel;
                    r_d   = r_sel;
                    if (sel == MC_CODE) begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(MC_LAT - 1);
                        mcs_d   = 1'b1;
                    end else begin
                        ov_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (flush_act || cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctr_q   <= '0;
            r_q     <= 1'b0;
            ov_q    <= 1'b0;
            mcs_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctr_q   <= ctr_d;
            r_q     <= r_d;
            ov_q    <= ov_d;
            mcs_q   <= mcs_d;
        end
    end

    // The multi-cycle completion strobe comes from the last BUSY cycle; a flush suppresses it.
    assign out_valid = ov_q || ((state_q == BUSY) && (cnt_q == '0) && !flush_act);
    assign alu_ctr   = ctr_q;
    assign is_r_type = r_q;
    assign mc_start  = mcs_q;
    assign stall     = (state_q == BUSY);
    assign dbg_state = (state_q == BUSY);

endmodule

// File: tb/tb_alu_ctr_select_seq.sv
// Bench for alu_ctr_select_seq: directed scenarios then random traffic against a cycle-schedule model.
module tb_alu_ctr_select_seq;
    localparam int MC_LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] ALUop = '0;
    logic [2:0] func_bits = '0;
    logic [2:0] alu_ctr;
    logic       is_r_type, out_valid, mc_start, stall, dbg_state;

    int checks = 0;
    int errors = 0;

    // model: expectations per cycle number, derived from accept times
    int cyc = 0;
    int busy_lo = -1, busy_hi = -1, ov_at = -1, mcs_at = -1;
    int m_ctr = 0, m_r = 0;

    always #5 clk = ~clk;

    alu_ctr_select_seq dut (
        .clk(clk), .rst_n(rst_n),
`ifdef ALU_CTR_SELECT_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .ALUop(ALUop), .func_bits(func_bits),
        .alu_ctr(alu_ctr), .is_r_type(is_r_type), .out_valid(out_valid),
        .mc_start(mc_start), .stall(stall), .dbg_state(dbg_state)
    );

    function automatic bit m_busy(int c);
        return (c >= busy_lo) && (c <= busy_hi);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("alu_ctr", 32'(alu_ctr), 32'(m_ctr));
        chk("is_r_type", 32'(is_r_type), 32'(m_r));
        chk("out_valid", 32'(out_valid), 32'(cyc == ov_at));
        chk("mc_start", 32'(mc_start), 32'(cyc == mcs_at));
        chk("stall", 32'(stall), 32'(m_busy(cyc)));
        chk("in_ready", 32'(in_ready), 32'(!m_busy(cyc)));
        chk("dbg_state", 32'(dbg_state), 32'(m_busy(cyc)));
    endtask

    // Drive one cycle of inputs, advance one edge, update the model, check the new cycle.
    task automatic step(input bit v, input int op, input int fn, input bit rst, input bit fl);
        bit acc, busy_now;
        int sel;
        in_valid  = v;
        ALUop     = 3'(op);
        func_bits = 3'(fn);
        rst_n     = rst;
        flush     = fl;
        busy_now  = m_busy(cyc);
`ifdef ALU_CTR_SELECT_FLUSH_EN
        acc = v && !busy_now && !fl;
`else
        acc = v && !busy_now;
`endif
        @(posedge clk);
        cyc++;
        flush = 1'b0;
        if (!rst) begin
            m_ctr = 0; m_r = 0;
            busy_lo = -1; busy_hi = -1; ov_at = -1; mcs_at = -1;
`ifdef ALU_CTR_SELECT_FLUSH_EN
        end else if (fl && busy_now) begin
            busy_lo = -1; busy_hi = -1; ov_at = -1;
`endif
        end else if (acc) begin
            m_r   = (op == 7) ? 1 : 0;
            sel   = (op == 7) ? fn : op;
            m_ctr = sel;
            if (sel == 5) begin
                busy_lo = cyc; busy_hi = cyc + MC_LAT - 1;
                mcs_at = cyc; ov_at = cyc + MC_LAT - 1;
            end else begin
                ov_at = cyc;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        // reset held with a request present
        step(1, 2, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        // I-type
        step(1, 2, 6, 1, 0);
        step(0, 0, 0, 1, 0);
        // R-type then I-type back-to-back
        step(1, 7, 6, 1, 0);
        step(1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        // multi-cycle with a request held across BUSY
        step(1, 7, 5, 1, 0);
        for (int i = 0; i < MC_LAT + 1; i++) step(1, 2, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        // MC via I-type code, then reset in the 2nd BUSY cycle
        step(1, 5, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < MC_LAT; i++) step(0, 0, 0, 1, 0);
`ifdef ALU_CTR_SELECT_FLUSH_EN
        // flush in the 2nd BUSY cycle with a simultaneous request
        step(1, 7, 5, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 3, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < MC_LAT; i++) step(0, 0, 0, 1, 0);
`endif
        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 40) != 0, $urandom_range(0, 15) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
